// File: rtl/phase_timer.sv
// Prescaled countdown timer: tick strobe every DIV enabled cycles, loadable countdown with done pulse.
// Optional PHASE_TIMER_BCD_EN adds saturating decimal digit outputs of the countdown value.
module phase_timer #(
  parameter int CLK_FREQ  = 50_000,
  parameter int TICK_HZ   = 1,
  parameter int SEC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 load,
  input  logic [SEC_WIDTH-1:0] load_value,
  output logic                 tick,
  output logic [SEC_WIDTH-1:0] remaining,
  output logic                 busy,
`ifdef PHASE_TIMER_BCD_EN
  output logic [3:0]           bcd_tens,
  output logic [3:0]           bcd_ones,
`endif
  output logic                 done
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if ((CLK_FREQ % TICK_HZ) != 0 || DIV < 2) begin : g_cfg_err
      $error("phase_timer: CLK_FREQ must be a multiple of TICK_HZ with DIV >= 2");
    end
  endgenerate

  logic [PW-1:0]        r_pre;
  logic [SEC_WIDTH-1:0] r_remaining;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_wrap;

  assign w_wrap = (r_pre == PW'(DIV - 1));
  assign tick   = w_wrap & enable;

  // Load takes priority over any tick in the same cycle and restarts the prescaler phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre       <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_pre       <= '0;
        r_remaining <= load_value;
        r_busy      <= (load_value != '0);
        r_done      <= (load_value == '0);
      end else begin
        if (enable)
          r_pre <= w_wrap ? '0 : r_pre + PW'(1);
        if (tick && r_busy) begin
          if (r_remaining == SEC_WIDTH'(1)) begin
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_remaining <= r_remaining - SEC_WIDTH'(1);
          end
        end
      end
    end
  end

  assign remaining = r_remaining;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef PHASE_TIMER_BCD_EN
  logic [6:0] w_sat;
  assign w_sat    = (32'(r_remaining) > 32'd99) ? 7'd99 : 7'(r_remaining);
  assign bcd_tens = 4'(w_sat / 7'd10);
  assign bcd_ones = 4'(w_sat % 7'd10);
`endif

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter CLK_FREQ, default 50_000: input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1: tick rate in Hz; DIV = CLK_FREQ / TICK_HZ.
REQ-003 Parameter SEC_WIDTH, default 8: width of the countdown value.
REQ-004 Port clk  input  1  clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port enable  input  1  high = prescaler and countdown run; low = pause.
REQ-007 Port load  input  1  single-cycle request to load load_value.
REQ-008 Port load_value  input  SEC_WIDTH  countdown start value in ticks.
REQ-009 Port tick  output  1  one-cycle strobe at TICK_HZ.
REQ-010 Port remaining  output  SEC_WIDTH  current countdown value, registered.
REQ-011 Port busy  output  1  high while the countdown is active, registered.
REQ-012 Port done  output  1  one-cycle completion pulse, registered.

Function
REQ-013 Prescaler: internal counter pre, width $clog2(DIV), counts 0..DIV-1 and wraps to 0; advances only when enable=1.
REQ-014 tick = (pre == DIV-1) AND enable, decoded combinationally from registered state; period is exactly DIV cycles while enable=1.
REQ-015 load=1 at edge N: remaining <= load_value, pre <= 0, busy <= (load_value != 0), done <= (load_value == 0); applies regardless of enable.
REQ-016 Latency: after a load at edge N with enable held high, the first decrement occurs at edge N+DIV and each later one every DIV cycles.
REQ-017 Tick while busy=1 and remaining>1: remaining <= remaining-1.
REQ-018 Tick while busy=1 and remaining==1: remaining <= 0, busy <= 0, done <= 1 for exactly one cycle.
REQ-019 Tick while busy=0: remaining unchanged, no done pulse; the prescaler keeps free-running.
REQ-020 load and tick in the same cycle: load wins; no decrement is applied.
REQ-021 enable=0: pre, remaining and busy hold; tick=0; resuming continues from the held pre value.
REQ-022 done is 0 in every cycle other than those defined in REQ-015 and REQ-018.
REQ-023 remaining never wraps below 0 and never exceeds 2^SEC_WIDTH-1.
REQ-024 Elaboration error when CLK_FREQ mod TICK_HZ != 0 or DIV < 2.

Reset
REQ-025 rst=1 immediately forces pre=0, remaining=0, busy=0 and done=0; tick reads 0.
REQ-026 rst asserted mid-countdown aborts the countdown with no done pulse.
REQ-027 After rst deasserts, the first tick occurs DIV cycles after the first enabled edge.

Configuration
REQ-028 Macro PHASE_TIMER_BCD_EN defined: extra output ports bcd_tens[3:0] and bcd_ones[3:0], combinational decimal digits of remaining; values >99 saturate to 9,9.
REQ-029 Macro PHASE_TIMER_BCD_EN undefined: bcd_tens and bcd_ones ports and their logic are absent; all other behaviour is identical.

Verification (CLK_FREQ=10, TICK_HZ=1, DIV=10, SEC_WIDTH=8)
REQ-030 Reset, enable=1, no load -> tick high 1 cycle every 10 cycles; remaining=0, busy=0, done=0 throughout.
REQ-031 load_value=3 at edge N -> remaining 3,2,1,0 after edges N, N+10, N+20, N+30; busy falls and done=1 for one cycle after edge N+30.
REQ-032 load 5, then enable=0 for 25 cycles after remaining=4 -> remaining stays 4 and tick=0; after re-enable the next decrement lands at the held prescaler phase.
REQ-033 load 7 while remaining=2 with tick asserted in the same cycle -> remaining=7, no decrement, next decrement 10 cycles later.
REQ-034 load_value=0 -> done=1 for one cycle, busy=0; rst pulse mid-count at remaining=6 -> all outputs 0 at once, no done.
REQ-035 With PHASE_TIMER_BCD_EN: remaining=47 -> bcd_tens=4, bcd_ones=7; remaining=150 -> bcd_tens=9, bcd_ones=9.
